// File: rtl/sketch_update_arbiter.sv
// Sketch counter SRAM read-modify-write sequencer with bounded-starvation host port.
// Optional SKETCH_CNT_SAT_EN: update sums saturate at all-ones instead of wrapping.
module sketch_update_arbiter #(
  parameter int ADDR_WIDTH    = 16,
  parameter int CNT_WIDTH     = 36,
  parameter int BYTE_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_UPD_BURST = 8
) (
  input  logic                  memclk,
  input  logic                  axi_aresetn,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_id,
  input  logic [BYTE_WIDTH-1:0] upd_bytes,
  output logic                  upd_full,
  output logic [15:0]           drop_cnt,
  input  logic                  host_req,
  input  logic                  host_op,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic                  host_ack,
  output logic [CNT_WIDTH-1:0]  host_rdata,
  output logic                  sram_req,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [CNT_WIDTH-1:0]  sram_wdata,
  input  logic                  sram_ready,
  input  logic [CNT_WIDTH-1:0]  sram_rdata,
  input  logic                  sram_rvalid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + BYTE_WIDTH;
  localparam int BW = $clog2(MAX_UPD_BURST + 1);
  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_UPD_BURST);
  localparam logic [BW-1:0] BURST_ONE = BW'(1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    HOST_RSP
  } state_t;

  state_t                state;
  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [EW-1:0]         head;
  logic [BYTE_WIDTH-1:0] cur_bytes;
  logic                  cur_host;
  logic [BW-1:0]         burst_cnt;
  logic                  host_skip;
  logic                  fifo_empty;
  logic                  host_seen;
  logic                  grant_upd;
  logic                  grant_host;
  logic                  push;
  logic                  pop;
  logic [CNT_WIDTH-1:0]  new_cnt;

  assign upd_full   = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = upd_valid && !upd_full;
  assign head       = fifo_mem[rd_ptr];

  // host is masked for one IDLE cycle after an ack so it can drop req
  assign host_seen  = host_req && !host_skip;
  assign grant_upd  = (state == IDLE) && !fifo_empty &&
                      (!host_seen || (burst_cnt < BURST_MAX));
  assign grant_host = (state == IDLE) && !grant_upd && host_seen;
  assign pop        = grant_upd;

`ifdef SKETCH_CNT_SAT_EN
  logic [CNT_WIDTH:0] sum_ext;
  assign sum_ext = {1'b0, sram_rdata} + (CNT_WIDTH+1)'(cur_bytes);
  assign new_cnt = sum_ext[CNT_WIDTH] ? '1 : sum_ext[CNT_WIDTH-1:0];
`else
  assign new_cnt = sram_rdata + CNT_WIDTH'(cur_bytes);
`endif

  always_ff @(posedge memclk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {upd_id, upd_bytes};
    end
  end

  always_ff @(posedge memclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (upd_valid && upd_full && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge memclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= IDLE;
      cur_bytes  <= '0;
      cur_host   <= 1'b0;
      burst_cnt  <= '0;
      host_skip  <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      sram_req   <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      host_skip <= 1'b0;
      if (!host_req) begin
        burst_cnt <= '0;
      end
      unique case (state)
        IDLE: begin
          if (grant_upd) begin
            sram_addr <= head[EW-1:BYTE_WIDTH];
            cur_bytes <= head[BYTE_WIDTH-1:0];
            cur_host  <= 1'b0;
            sram_req  <= 1'b1;
            sram_we   <= 1'b0;
            state     <= RD_REQ;
            if (host_req) begin
              burst_cnt <= burst_cnt + BURST_ONE;
            end
          end else if (grant_host) begin
            sram_addr <= host_addr;
            cur_host  <= 1'b1;
            burst_cnt <= '0;
            sram_req  <= 1'b1;
            if (host_op) begin
              sram_we    <= 1'b1;
              sram_wdata <= '0;
              state      <= WR_REQ;
            end else begin
              sram_we <= 1'b0;
              state   <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (sram_ready) begin
            sram_req <= 1'b0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (sram_rvalid) begin
            if (cur_host) begin
              host_rdata <= sram_rdata;
              host_ack   <= 1'b1;
              state      <= HOST_RSP;
            end else begin
              sram_wdata <= new_cnt;
              sram_req   <= 1'b1;
              sram_we    <= 1'b1;
              state      <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (sram_ready) begin
            sram_req <= 1'b0;
            sram_we  <= 1'b0;
            if (cur_host) begin
              host_ack <= 1'b1;
              state    <= HOST_RSP;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOST_RSP: begin
          host_ack  <= 1'b0;
          host_skip <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sketch_update_arbiter.sv
// Directed bench for sketch_update_arbiter with a one-cycle-latency SRAM model.
module tb_sketch_update_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic [15:0] upd_id;
  logic [15:0] upd_bytes;
  logic        upd_full;
  logic [15:0] drop_cnt;
  logic        host_req;
  logic        host_op;
  logic [15:0] host_addr;
  logic        host_ack;
  logic [35:0] host_rdata;
  logic        sram_req;
  logic        sram_we;
  logic [15:0] sram_addr;
  logic [35:0] sram_wdata;
  logic        sram_ready;
  logic [35:0] sram_rdata;
  logic        sram_rvalid;

  logic        m_rvalid;
  logic [35:0] m_rdata;
  logic        stray_rv;
  logic        hold_rd;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [35:0] pre_data;

  logic [35:0] mem [256];
  logic [15:0] wr_addr_q [$];
  logic [35:0] wr_data_q [$];
  int          n_reads;
  int          cyc;
  int          last_wr_cyc;

  int errors = 0;
  int checks = 0;

  assign sram_rvalid = m_rvalid | stray_rv;
  assign sram_rdata  = m_rdata;

  always #5 clk = ~clk;

  sketch_update_arbiter dut (
    .memclk      (clk),
    .axi_aresetn (rst_n),
    .upd_valid   (upd_valid),
    .upd_id      (upd_id),
    .upd_bytes   (upd_bytes),
    .upd_full    (upd_full),
    .drop_cnt    (drop_cnt),
    .host_req    (host_req),
    .host_op     (host_op),
    .host_addr   (host_addr),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .sram_req    (sram_req),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_ready  (sram_ready),
    .sram_rdata  (sram_rdata),
    .sram_rvalid (sram_rvalid)
  );

  // SRAM model: one-cycle read latency, logs every accepted write
  initial begin
    n_reads     = 0;
    cyc         = 0;
    last_wr_cyc = -1;
  end

  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
    end else if (pre_we) begin
      mem[pre_addr] = pre_data;
    end
    if (sram_req && sram_ready) begin
      if (sram_we) begin
        mem[sram_addr[7:0]] = sram_wdata;
        wr_addr_q.push_back(sram_addr);
        wr_data_q.push_back(sram_wdata);
        last_wr_cyc = cyc;
      end else begin
        n_reads = n_reads + 1;
        if (!hold_rd) begin
          m_rvalid <= 1'b1;
          m_rdata  <= mem[sram_addr[7:0]];
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [35:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic push(input logic [15:0] id, input logic [15:0] b);
    upd_valid = 1'b1;
    upd_id    = id;
    upd_bytes = b;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n);
    for (int i = 0; i < 400 && wr_addr_q.size() < n; i++) @(negedge clk);
    check(tag, 64'(wr_addr_q.size() >= n), 64'd1);
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 400 && !host_ack; i++) @(negedge clk);
    check(tag, 64'(host_ack), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_full"},  64'(upd_full),   64'd0);
    check({tag, "_drop"},  64'(drop_cnt),   64'd0);
    check({tag, "_ack"},   64'(host_ack),   64'd0);
    check({tag, "_rdata"}, 64'(host_rdata), 64'd0);
    check({tag, "_req"},   64'(sram_req),   64'd0);
    check({tag, "_we"},    64'(sram_we),    64'd0);
    check({tag, "_addr"},  64'(sram_addr),  64'd0);
    check({tag, "_wdata"}, 64'(sram_wdata), 64'd0);
  endtask

  initial begin
    int nw;
    int nr;
    int ack_cyc;
    logic [35:0] sat_exp;

    rst_n      = 1'b0;
    upd_valid  = 1'b0;
    upd_id     = '0;
    upd_bytes  = '0;
    host_req   = 1'b0;
    host_op    = 1'b0;
    host_addr  = '0;
    sram_ready = 1'b1;
    stray_rv   = 1'b0;
    hold_rd    = 1'b0;
    pre_we     = 1'b0;
    pre_addr   = '0;
    pre_data   = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // single update
    preload(8'd5, 36'h100);
    nw = wr_addr_q.size();
    nr = n_reads;
    push(16'd5, 16'd64);
    wait_writes("single_wait", nw + 1);
    check("single_addr", 64'(wr_addr_q[nw]), 64'd5);
    check("single_data", 64'(wr_data_q[nw]), 64'h140);
    check("single_reads", 64'(n_reads - nr), 64'd1);
    repeat (3) @(negedge clk);
    check("single_idle_req", 64'(sram_req), 64'd0);
    check("single_drop", 64'(drop_cnt), 64'd0);

    // overflow: host read stalls the FSM while 20 updates arrive
    preload(8'd7, 36'h55);
    sram_ready = 1'b0;
    host_op    = 1'b0;
    host_addr  = 16'd7;
    host_req   = 1'b1;
    repeat (2) @(negedge clk);
    check("ovf_stall_req", 64'(sram_req), 64'd1);
    nw = wr_addr_q.size();
    for (int i = 0; i < 20; i++) begin
      upd_valid = 1'b1;
      upd_id    = 16'(20 + i);
      upd_bytes = 16'(i + 1);
      @(negedge clk);
    end
    upd_valid = 1'b0;
    check("ovf_full", 64'(upd_full), 64'd1);
    check("ovf_drop", 64'(drop_cnt), 64'd4);
    sram_ready = 1'b1;
    wait_ack("ovf_host_ack");
    check("ovf_host_rdata", 64'(host_rdata), 64'h55);
    host_req = 1'b0;
    wait_writes("ovf_wait", nw + 16);
    for (int i = 0; i < 16; i++) begin
      check("ovf_order_addr", 64'(wr_addr_q[nw + i]), 64'(20 + i));
      check("ovf_order_data", 64'(wr_data_q[nw + i]), 64'(i + 1));
    end
    repeat (10) @(negedge clk);
    check("ovf_no_extra", 64'(wr_addr_q.size() - nw), 64'd16);
    check("ovf_not_full", 64'(upd_full), 64'd0);

    // starvation bound: host read of addr 9 waits behind 8 updates
    preload(8'd9, 36'h77);
    sram_ready = 1'b0;
    nw = wr_addr_q.size();
    for (int i = 0; i < 10; i++) begin
      upd_valid = 1'b1;
      upd_id    = 16'(40 + i);
      upd_bytes = 16'd1;
      if (i == 1) begin
        host_op   = 1'b0;
        host_addr = 16'd9;
        host_req  = 1'b1;
      end
      @(negedge clk);
    end
    upd_valid  = 1'b0;
    sram_ready = 1'b1;
    wait_ack("starve_ack");
    check("starve_writes", 64'(wr_addr_q.size() - nw), 64'd8);
    check("starve_rdata", 64'(host_rdata), 64'h77);
    host_req = 1'b0;
    wait_writes("starve_rest", nw + 10);
    check("starve_last_addr", 64'(wr_addr_q[nw + 9]), 64'd49);

    // host clear
    preload(8'd3, 36'hABC);
    nw = wr_addr_q.size();
    nr = n_reads;
    host_op   = 1'b1;
    host_addr = 16'd3;
    host_req  = 1'b1;
    wait_ack("clr_ack");
    ack_cyc  = cyc;
    host_req = 1'b0;
    host_op  = 1'b0;
    check("clr_writes", 64'(wr_addr_q.size() - nw), 64'd1);
    check("clr_addr", 64'(wr_addr_q[nw]), 64'd3);
    check("clr_data", 64'(wr_data_q[nw]), 64'd0);
    check("clr_no_read", 64'(n_reads - nr), 64'd0);
    check("clr_ack_timing", 64'(ack_cyc - last_wr_cyc), 64'd1);
    @(negedge clk);
    check("clr_ack_pulse", 64'(host_ack), 64'd0);
    repeat (2) @(negedge clk);

    // saturation or wrap at the counter width
    preload(8'd1, 36'hF_FFFF_FFF0);
    nw = wr_addr_q.size();
`ifdef SKETCH_CNT_SAT_EN
    sat_exp = 36'hF_FFFF_FFFF;
`else
    sat_exp = 36'h0_0000_0010;
`endif
    push(16'd1, 16'h20);
    wait_writes("sat_wait", nw + 1);
    check("sat_addr", 64'(wr_addr_q[nw]), 64'd1);
    check("sat_data", 64'(wr_data_q[nw]), 64'(sat_exp));
    repeat (2) @(negedge clk);

    // reset while waiting for read data, then a stray rvalid
    hold_rd = 1'b1;
    nr = n_reads;
    push(16'd2, 16'd5);
    push(16'd2, 16'd6);
    push(16'd2, 16'd7);
    for (int i = 0; i < 50 && n_reads == nr; i++) @(negedge clk);
    check("rst_read_issued", 64'(n_reads - nr), 64'd1);
    nw = wr_addr_q.size();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    hold_rd  = 1'b0;
    nr       = n_reads;
    stray_rv = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_write", 64'(wr_addr_q.size() - nw), 64'd0);
    check("rst_fifo_empty", 64'(n_reads - nr), 64'd0);
    check_idle_outputs("rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sketch_update_arbiter.md
# sketch_update_arbiter

Read-modify-write controller and arbiter for the sketch counter SRAM. It buffers `(SRAM_ID, packet_byte)` update pairs from the hash/byte-count path and sequences each one as an SRAM read, add and write-back. It shares the same SRAM port with a host read/clear port under bounded-starvation arbitration. It sits between the sketch hash pipeline and the SRAM memory interface, in the 200 MHz `memclk` domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: SRAM word address width; equals update ID width.
- `CNT_WIDTH`, 36: SRAM word / counter width (byte counter).
- `BYTE_WIDTH`, 16: update byte-count width.
- `FIFO_DEPTH`, 16: update FIFO entries, power of two.
- `MAX_UPD_BURST`, 8: maximum consecutive update grants while a host request waits.

Ports:
- `memclk` in 1: 200 MHz clock; all logic on the rising edge.
- `axi_aresetn` in 1: asynchronous, active-low reset.
- `upd_valid` in 1: one-cycle update strobe. No backpressure.
- `upd_id` in ADDR_WIDTH: counter address.
- `upd_bytes` in BYTE_WIDTH: bytes to add.
- `upd_full` out 1: update FIFO full.
- `drop_cnt` out 16: updates dropped on full; saturates at 16'hFFFF.
- `host_req` in 1: host request, level, held until `host_ack`.
- `host_op` in 1: 0 = read, 1 = clear. Stable while `host_req` is high.
- `host_addr` in ADDR_WIDTH: host target address.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out CNT_WIDTH: read result. Valid with `host_ack`; holds its value otherwise.
- `sram_req` out 1: SRAM command valid.
- `sram_we` out 1: 1 = write, 0 = read.
- `sram_addr` out ADDR_WIDTH: command address.
- `sram_wdata` out CNT_WIDTH: write data.
- `sram_ready` in 1: a command is accepted on a cycle where `sram_req && sram_ready`.
- `sram_rdata` in CNT_WIDTH: read data.
- `sram_rvalid` in 1: read data valid, one cycle, in order.

## Operation
- **Update FIFO**
  - `upd_valid` with FIFO not full: push `{upd_id, upd_bytes}`.
  - `upd_valid` with FIFO full: drop the update and increment `drop_cnt`.
  - `upd_full` is combinational from the occupancy count.
  - Simultaneous push and pop with FIFO full: the pop takes effect after the full check, so the push is dropped.
- **FSM states**: IDLE, RD_REQ, RD_WAIT, WR_REQ, HOST_RSP.
- **IDLE arbitration**
  - Grant an update if the FIFO is non-empty and (`!host_req` or `burst_cnt < MAX_UPD_BURST`). Pop the FIFO head into `cur_addr` / `cur_bytes`, set `cur_host=0`, increment `burst_cnt` if `host_req`. Go to RD_REQ.
  - Otherwise, if `host_req`: latch `host_addr` and `host_op`, set `cur_host=1`, clear `burst_cnt`.
    - Clear op: load `cur_wdata=0` and go to WR_REQ.
    - Read op: go to RD_REQ.
  - `burst_cnt` clears whenever `host_req` is low.
- **RD_REQ**: drive `sram_req=1`, `sram_we=0`, `sram_addr=cur_addr`. On accept, go to RD_WAIT.
- **RD_WAIT**: on `sram_rvalid`:
  - Host read: capture `sram_rdata` into `host_rdata` and go to HOST_RSP.
  - Update: compute `cur_wdata = sram_rdata + zero-extended cur_bytes`, modulo 2^CNT_WIDTH. Go to WR_REQ.
- **WR_REQ**: drive `sram_req=1`, `sram_we=1`, `sram_wdata=cur_wdata`. On accept, go to HOST_RSP if `cur_host`, else IDLE.
- **HOST_RSP**: `host_ack=1` for one cycle, then IDLE. The next IDLE cycle ignores `host_req` for host selection, so the host has one cycle to deassert.
- `sram_rvalid` outside RD_WAIT is ignored.
- Only one SRAM transaction is outstanding at a time, so no read-after-write hazard exists.

## Timing
- **Reset values** (all outputs 0): `upd_full=0`, `drop_cnt=0`, `host_ack=0`, `host_rdata=0`, `sram_req=0`, `sram_we=0`, `sram_addr=0`, `sram_wdata=0`. FSM in IDLE, FIFO empty, `burst_cnt=0`.
- **Reset mid-operation**: all state is cleared asynchronously and pending FIFO entries are lost. A late `sram_rvalid` after reset is ignored.
- **Latency**
  - FIFO push to visible non-empty: 1 cycle.
  - IDLE to RD_REQ: 1 cycle.
  - With `sram_ready=1` and read latency L (command accept to `rvalid`), one update occupies 3+L cycles from leaving IDLE to returning to IDLE.
- **Handshake**: `sram_req` and its address/data are registered and held stable until accepted. `sram_req` drops in the cycle after acceptance.
- Host worst-case wait: MAX_UPD_BURST update transactions plus the one in flight.

## Configuration
- `SKETCH_CNT_SAT_EN`
  - Defined: the update sum saturates at all-ones CNT_WIDTH (carry-out forces all-ones).
  - Undefined: the sum wraps modulo 2^CNT_WIDTH.
- Host clear is unaffected by this macro.

## Test plan
- **Single update**: SRAM model holds 0x100 at address 5; `upd_id=5`, `upd_bytes=64` → one read of addr 5, then a write of 0x140. FSM returns to IDLE; `drop_cnt=0`.
- **FIFO overflow**: hold `sram_ready=0` and push 20 updates → `upd_full` asserts after 16, `drop_cnt=4`. Release ready → exactly 16 RMWs occur in push order.
- **Starvation bound**: FIFO kept non-empty and `host_req` read of addr 9 (value 0x77) held → `host_ack` follows after exactly 8 update writes, with `host_rdata=0x77`.
- **Host clear**: clear addr 3 holding 0xABC → one write of 0 to addr 3 with no read. `host_ack` pulses once, 1 cycle after write accept.
- **Saturation**: addr 1 = 0xF_FFFF_FFF0, add 0x20 → writes 0xF_FFFF_FFFF with `SKETCH_CNT_SAT_EN`, 0x0_0000_0010 without.
- **Reset during RD_WAIT**: assert `axi_aresetn=0` for 2 cycles, then feed a stray `sram_rvalid` → no write issued, all outputs 0, FIFO empty.
